aidc_lite_decomp_ctrl: RTL
==========================

// Module: aidc_lite_decomp_ctrl
// PURPOSE
//  Sequences one compressed packet at a time into NUM_DEC single-beat-write decompressor
//  lanes. Steers input beats to the lane chosen at SOP, merges the lanes' OR-shared write
//  ports into a 16x64b line buffer, and presents the completed 128B line downstream with a
//  valid/ready handshake. Sits between the compressed-line ingress and the decompressor bank.
// PARAMETERS
//  NUM_DEC    4    number of decompressor lanes (1..2**SEL_W)
//  SEL_W      2    width of lane-select field
//  TIMEOUT    64   WAIT watchdog limit in cycles (used only with the optional watchdog)
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           asynchronous active-low reset
//  in_valid_i   in   1           input beat valid
//  in_ready_o   out  1           input beat accepted when valid&ready
//  in_sop_i     in   1           first beat of packet
//  in_eop_i     in   1           last beat of packet
//  in_sel_i     in   SEL_W       target lane; sampled only on an accepted SOP beat
//  in_data_i    in   32          compressed beat
//  dec_valid_o  out  NUM_DEC     one-hot per-lane beat valid
//  dec_sop_o    out  1           broadcast SOP
//  dec_eop_o    out  1           broadcast EOP
//  dec_data_o   out  32          broadcast beat data
//  wr_valid_i   in   NUM_DEC     per-lane buffer write valid
//  wr_addr_i    in   4*NUM_DEC   per-lane write address; 0 when that lane is idle
//  wr_data_i    in   64*NUM_DEC  per-lane write data; 0 when that lane is idle
//  line_valid_o out  1           decompressed line valid
//  line_ready_i in   1           downstream accepts line
//  line_data_o  out  1024        line; entry k at bits [64k+63:64k]
//  err_o        out  1           one-cycle error pulse
//  err_code_o   out  3           1 bad sel, 2 overflow, 3 orphan/stray SOP, 4 write conflict, 5 timeout
// BEHAVIOUR
//  Reset values: in_ready_o=0 in reset, then 1 in IDLE; dec_*=0; line_valid_o=0; line buffer=0;
//   err_o=0; err_code_o=0; state=IDLE; lane sel=0; beat/write counters=0.
//  States:
//  - IDLE: in_ready=1. Accepted SOP clears all 16 buffer entries, latches sel, forwards the
//    beat, and goes to STREAM; if it is also EOP, goes to WAIT instead. An accepted non-SOP
//    beat is dropped with err 3. SOP with sel>=NUM_DEC: the packet is accepted and dropped
//    through EOP, err 1 once, then back to IDLE; no line is produced.
//  - STREAM: in_ready=1. Each accepted beat is forwarded. A SOP beat inside STREAM is
//    forwarded with dec_sop_o=0 and raises err 3. Accepted EOP goes to WAIT.
//  - WAIT: in_ready=0. Exit to OUT when wr_cnt==fwd_cnt, i.e. every forwarded beat has
//    produced one write.
//  - OUT: line_valid_o=1; line_data_o stable until line_ready_i. Handshake returns to IDLE;
//    in_ready rises the following cycle.
//  Forwarding: 1-cycle registered latency. dec_valid_o[sel], dec_sop_o, dec_eop_o and
//   dec_data_o are all 0 when no beat is forwarded (no backpressure toward the lanes).
//  Overflow: beats beyond 16 (fwd_cnt==16) are accepted but not forwarded; err 2 fires once
//   per packet. fwd_cnt and wr_cnt are 5 bits and saturate at 16.
//  Writes: merged addr = OR of lanes, merged data = OR of lanes. When any wr_valid_i bit is
//   set, buf[addr] is written the same cycle and wr_cnt increments. More than one lane valid,
//   or a write from a non-selected lane: err 4, the write is still performed, and wr_cnt
//   still increments by 1. Writes in IDLE or OUT: err 4 and ignored.
//  Simultaneous errors: lowest code wins; one pulse per cycle.
//  Reset mid-operation: immediate return to reset values; any partial line is discarded.
// CONFIGURATION
//  AIDC_LITE_DECOMP_CTRL_TIMEOUT_EN defined: a 7-bit watchdog counts cycles in WAIT. When it
//   reaches TIMEOUT: err 5, go to OUT with the partial line (unwritten entries are 0),
//   counter clears. Not defined: no watchdog logic; WAIT holds indefinitely.
// TESTING
//  - Reset: rst_n low mid-STREAM -> all outputs 0 immediately; line_valid_o=0; in_ready_o=1
//    one cycle after release.
//  - Normal: SOP sel=2, 16 beats, lane 2 writes addr 0..15 with data 0x1111*k ->
//    dec_valid_o=4'b0100 one cycle after each accept; line_valid_o after 16th write;
//    entry k = 0x1111*k.
//  - Short packet: 1-beat SOP+EOP to lane 0 -> state WAIT directly; line has only entry 0
//    written, rest 0.
//  - Bad sel / overflow: sel=3 with NUM_DEC=3 -> err_code 1, no dec_valid, no line.
//    Then 18-beat packet -> err_code 2 once, exactly 16 beats forwarded.
//  - Conflict and backpressure: lanes 0 and 1 write the same cycle -> err_code 4; hold
//    line_ready_i low 10 cycles -> line_data_o stable, in_ready_o=0.
//  - Timeout (macro on, TIMEOUT=8): lane never writes -> err_code 5 after 8 WAIT cycles;
//    line_valid_o=1 with all-zero line.

Source files
------------

// File: rtl/aidc_lite_decomp_ctrl.sv
// ---------------------------------------------------------------------------
// aidc_lite_decomp_ctrl
//   Sequences one compressed packet at a time into NUM_DEC decompressor lanes.
//   The lane picked on the SOP beat receives every beat of the packet through a
//   one-cycle registered broadcast. The lanes' OR-shared single-beat write ports
//   fill a 16 x 64b line buffer. Once every forwarded beat has produced one write,
//   the 128B line is offered downstream with a valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      compressed beat handshake
//   in_sop_i/in_eop_i          packet delimiters
//   in_sel_i                   target lane, sampled on an accepted SOP beat
//   in_data_i                  compressed beat
//   dec_valid_o                one-hot per-lane beat valid (registered)
//   dec_sop_o/dec_eop_o        broadcast delimiters (registered)
//   dec_data_o                 broadcast beat data (registered)
//   wr_valid_i/addr_i/data_i   per-lane buffer write ports (idle lanes drive 0)
//   line_valid_o/line_ready_i  decompressed line handshake
//   line_data_o                line, entry k at bits [64k+63:64k]
//   err_o/err_code_o           one-cycle error pulse; 1 bad sel, 2 overflow,
//                              3 orphan/stray SOP, 4 write conflict, 5 timeout
//
// Build option
//   AIDC_LITE_DECOMP_CTRL_TIMEOUT_EN : adds a WAIT watchdog of TIMEOUT cycles that
//   forces the partial line out with error 5. Without it WAIT holds indefinitely.
// ---------------------------------------------------------------------------
module aidc_lite_decomp_ctrl #(
  parameter int NUM_DEC = 4,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_sop_i,
  input  logic                  in_eop_i,
  input  logic [SEL_W-1:0]      in_sel_i,
  input  logic [31:0]           in_data_i,
  output logic [NUM_DEC-1:0]    dec_valid_o,
  output logic                  dec_sop_o,
  output logic                  dec_eop_o,
  output logic [31:0]           dec_data_o,
  input  logic [NUM_DEC-1:0]    wr_valid_i,
  input  logic [4*NUM_DEC-1:0]  wr_addr_i,
  input  logic [64*NUM_DEC-1:0] wr_data_i,
  output logic                  line_valid_o,
  input  logic                  line_ready_i,
  output logic [1023:0]         line_data_o,
  output logic                  err_o,
  output logic [2:0]            err_code_o
);

  if (NUM_DEC < 1 || NUM_DEC > (1 << SEL_W) || TIMEOUT < 1 || TIMEOUT > 128) begin : g_param_check
    $error("aidc_lite_decomp_ctrl: illegal NUM_DEC/SEL_W/TIMEOUT combination");
  end

  // S_DROP swallows a packet whose SOP named a non-existent lane.
  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DROP, S_WAIT, S_OUT} state_t;

  localparam logic [4:0] LINE_ENTRIES = 5'd16;

  state_t              state_q;
  logic [SEL_W-1:0]    sel_q;
  logic [4:0]          fwd_cnt_q;
  logic [4:0]          wr_cnt_q;
  logic                ovf_q;
  logic [63:0]         line_q [16];

  logic [NUM_DEC-1:0]  dec_valid_p1;
  logic                dec_sop_p1;
  logic                dec_eop_p1;
  logic [31:0]         dec_data_p1;

  logic                acc, sel_bad, fwd_room, wait_done, to_hit;
  logic                wr_any, wr_multi, wr_foreign, wr_take;
  logic [NUM_DEC-1:0]  sel_onehot;
  logic [3:0]          wr_addr;
  logic [63:0]         wr_data;
  logic [4:0]          err_flags;

  function automatic logic [4:0] sat_inc(input logic [4:0] c);
    return (c >= LINE_ENTRIES) ? LINE_ENTRIES : c + 5'd1;
  endfunction

  // Flag bit i stands for error code i+1; the lowest set code wins.
  function automatic logic [2:0] err_pick(input logic [4:0] f);
    logic [2:0] code;
    code = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (f[i]) code = 3'(i + 1);
    end
    return code;
  endfunction

  // ---- stage 0: accept, write merge and error detection ----
  assign acc        = in_valid_i & in_ready_o;
  assign sel_bad    = int'(in_sel_i) >= NUM_DEC;
  assign fwd_room   = fwd_cnt_q < LINE_ENTRIES;
  assign wait_done  = wr_cnt_q == fwd_cnt_q;
  assign sel_onehot = NUM_DEC'(1) << sel_q;
  assign wr_any     = |wr_valid_i;
  assign wr_multi   = (wr_valid_i & (wr_valid_i - NUM_DEC'(1))) != '0;
  assign wr_foreign = (wr_valid_i & ~sel_onehot) != '0;
  assign wr_take    = wr_any & ((state_q == S_STREAM) | (state_q == S_WAIT));

  // Idle lanes drive zeros, so a plain OR recovers the active lane's write.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_DEC; i++) begin
      wr_addr = wr_addr | wr_addr_i[4*i +: 4];
      wr_data = wr_data | wr_data_i[64*i +: 64];
    end
  end

  always_comb begin
    err_flags    = '0;
    err_flags[0] = acc & in_sop_i & sel_bad & (state_q == S_IDLE);
    err_flags[1] = acc & ~fwd_room & ~ovf_q & (state_q == S_STREAM);
    err_flags[2] = acc & (((state_q == S_IDLE) & ~in_sop_i) |
                          (((state_q == S_STREAM) | (state_q == S_DROP)) & in_sop_i));
    err_flags[3] = wr_any & (~wr_take | wr_multi | wr_foreign);
    err_flags[4] = to_hit;
  end

`ifdef AIDC_LITE_DECOMP_CTRL_TIMEOUT_EN
  logic [6:0] wd_q;

  assign to_hit = (state_q == S_WAIT) & ~wait_done & (wd_q == 7'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if ((state_q == S_WAIT) && !wait_done && !to_hit) begin
      wd_q <= wd_q + 7'd1;
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // ---- stage 1: control FSM, line buffer, registered lane broadcast ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      in_ready_o   <= 1'b0;
      sel_q        <= '0;
      fwd_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      line_valid_o <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= '0;
      dec_valid_p1 <= '0;
      dec_sop_p1   <= 1'b0;
      dec_eop_p1   <= 1'b0;
      dec_data_p1  <= '0;
      for (int k = 0; k < 16; k++) line_q[k] <= '0;
    end else begin
      dec_valid_p1 <= '0;
      dec_sop_p1   <= 1'b0;
      dec_eop_p1   <= 1'b0;
      dec_data_p1  <= '0;
      err_o        <= |err_flags;
      err_code_o   <= err_pick(err_flags);

      // A conflicting write still lands and still counts as one write.
      if (wr_take) begin
        line_q[wr_addr] <= wr_data;
        wr_cnt_q        <= sat_inc(wr_cnt_q);
      end

      case (state_q)
        S_IDLE: begin
          in_ready_o <= 1'b1;
          if (acc && in_sop_i) begin
            for (int k = 0; k < 16; k++) line_q[k] <= '0;
            fwd_cnt_q <= '0;
            wr_cnt_q  <= '0;
            ovf_q     <= 1'b0;
            if (sel_bad) begin
              if (!in_eop_i) state_q <= S_DROP;
            end else begin
              sel_q        <= in_sel_i;
              dec_valid_p1 <= NUM_DEC'(1) << in_sel_i;
              dec_sop_p1   <= 1'b1;
              dec_eop_p1   <= in_eop_i;
              dec_data_p1  <= in_data_i;
              fwd_cnt_q    <= 5'd1;
              if (in_eop_i) begin
                state_q    <= S_WAIT;
                in_ready_o <= 1'b0;
              end else begin
                state_q <= S_STREAM;
              end
            end
          end
        end
        S_DROP: begin
          if (acc && in_eop_i) state_q <= S_IDLE;
        end
        S_STREAM: begin
          if (acc) begin
            // Beats past the 16-entry line are consumed but never reach a lane.
            if (fwd_room) begin
              dec_valid_p1 <= sel_onehot;
              dec_eop_p1   <= in_eop_i;
              dec_data_p1  <= in_data_i;
              fwd_cnt_q    <= fwd_cnt_q + 5'd1;
            end else begin
              ovf_q <= 1'b1;
            end
            if (in_eop_i) begin
              state_q    <= S_WAIT;
              in_ready_o <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (wait_done || to_hit) begin
            state_q      <= S_OUT;
            line_valid_o <= 1'b1;
          end
        end
        S_OUT: begin
          if (line_ready_i) begin
            state_q      <= S_IDLE;
            line_valid_o <= 1'b0;
            in_ready_o   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dec_valid_o = dec_valid_p1;
  assign dec_sop_o   = dec_sop_p1;
  assign dec_eop_o   = dec_eop_p1;
  assign dec_data_o  = dec_data_p1;

  always_comb begin
    line_data_o = '0;
    for (int k = 0; k < 16; k++) line_data_o[64*k +: 64] = line_q[k];
  end

endmodule
